mem_access_unit: RTL
====================

# mem_access_unit

Memory-stage load/store unit for the three-stage RISC-V core. It consumes the registered store width (`MemRW_reg`) and load type (`LdSel_reg`) from decode, together with the execute-stage address and store data. It drives the synchronous DMEM port with byte enables and lane-shifted data, and aligns and extends load data one cycle later. It also owns the memory-mapped cycle and instruction counters.

## Interface
Parameters:
- `DMEM_AWIDTH`, default 14: DMEM word-address width.

Ports:
- `clk`  in  1: core clock.
- `rst`  in  1: reset. Synchronous, active-high.
- `mem_rw`  in  2: store width. 00 none, 01 SW, 10 SH, 11 SB.
- `ld_sel`  in  3: load funct3. 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `ld_en`  in  1: the current execute instruction is a load (`WBSel_reg` == DMEM).
- `addr`  in  32: effective address from the ALU.
- `store_data`  in  32: forwarded rs2 value.
- `stall`  in  1: load-use hold. Suppresses the access and freezes the load pipeline register.
- `flush`  in  1: control-hazard kill of the current execute instruction.
- `inst_retire`  in  1: one instruction retired this cycle.
- `dmem_addr`  out  DMEM_AWIDTH: equals `addr[DMEM_AWIDTH+1:2]`.
- `dmem_din`  out  32: lane-shifted store data.
- `dmem_we`  out  4: byte write enables.
- `dmem_dout`  in  32: DMEM read data, valid one cycle after the address.
- `load_data`  out  32: aligned and extended load result, valid in the writeback cycle.
- `cycle_count`  out  32: free-running cycle counter.
- `inst_count`  out  32: retired-instruction counter.

## Operation
Address decode:
- DMEM region: `addr[31:28]` is 0001 or 0011.
- IO region: `addr[31:28]` is 1000.
- Any other region: no write occurs, and a load returns 0.

Store path (combinational, execute cycle):
- Stores are gated by `~stall & ~flush` and by the DMEM region.
- SW: `dmem_we`=1111, `dmem_din`=`store_data`. `addr[1:0]` is ignored.
- SH: `dmem_we`=0011 when `addr[1]`=0, 1100 when `addr[1]`=1. `dmem_din`=`{2{store_data[15:0]}}`. `addr[0]` is ignored.
- SB: `dmem_we`=`4'b0001<<addr[1:0]`. `dmem_din`=`{4{store_data[7:0]}}`.
- No store (`mem_rw`=00): `dmem_we`=0000.

Counter reset via store:
- Any store with `addr`=0x8000_0018 in the IO region zeroes both counters on the next edge. The clear has priority over increment.

Load pipeline register (updates when `~stall`):
- `ld_v_q` <= `ld_en & ~flush`.
- `ld_sel_q` <= `ld_sel`.
- `off_q` <= `addr[1:0]`.
- `rgn_q` <= {DMEM, IO-cycle (0x8000_0010), IO-inst (0x8000_0014), other}.
- `io_q` <= the selected counter value, sampled in the execute cycle.

Load extraction (writeback cycle, combinational from the registered fields):
- Source word: `dmem_dout` for DMEM, `io_q` for IO, 0 otherwise.
- LB/LBU: byte `off_q`, sign- or zero-extended to 32 bits.
- LH/LHU: halfword `off_q[1]`, extended.
- LW: the full word.
- Undefined `ld_sel` codes are treated as LW.
- When `ld_v_q`=0: `load_data`=0.

Counters:
- `cycle_count` increments every cycle that is not reset or cleared.
- `inst_count` increments when `inst_retire`=1.
- Both wrap modulo 2^32.

## Timing
- Reset values: counters 0; `ld_v_q`, `ld_sel_q`, `off_q`, `rgn_q`, `io_q` all 0. Therefore `load_data`=0 in the first cycle after reset.
- `dmem_we` is combinational. It is 0000 whenever `rst`=1, regardless of the other inputs.
- Store: committed at the edge ending the execute cycle. There is no handshake.
- Load latency: the address is presented in cycle N, and `load_data` is valid throughout cycle N+1.
- Stall in cycle N:
  - No DMEM write.
  - Load registers hold their values, so `load_data` in N+1 repeats the N value.
  - Counters still run.
- Flush with a load: `ld_v_q`=0 next cycle.
- Flush with a store: no write.
- Simultaneous counter-clear store and `inst_retire`: the counters read 0 after the edge.
- Counter read at 0x8000_0010 in cycle N returns the value of `cycle_count` during cycle N.
- Reset asserted mid-load: the pending load is dropped, and `load_data`=0 in the following cycle.

## Test plan
- **SB sweep:** `store_data`=0x0000_00A5, `addr`=0x1000_0000..0x1000_0003, `mem_rw`=11. Required: `dmem_we`=0001, 0010, 0100, 1000, and `dmem_din`=0xA5A5_A5A5 each cycle.
- **LH/LHU alignment:** DMEM word 0x8001_7FFF.
  - LH at offset 0 -> 0x0000_7FFF.
  - LH at offset 2 -> 0xFFFF_8001.
  - LHU at offset 2 -> 0x0000_8001.
  - Each result appears one cycle after the address.
- **LB/LBU sign extension:** DMEM word 0x12F0_3456.
  - LB at offset 2 -> 0xFFFF_FFF0.
  - LBU at offset 2 -> 0x0000_00F0.
- **Stall and flush:**
  - SW with `stall`=1 -> `dmem_we`=0000.
  - LW with `flush`=1 -> `load_data`=0 next cycle.
  - LW, then 3 stall cycles -> `load_data` is held constant.
- **Counters:**
  - After reset plus 100 idle cycles, LW from 0x8000_0010 returns 100.
  - Pulse `inst_retire` 7 times, then LW from 0x8000_0014 returns 7.
  - SW to 0x8000_0018, then both counters read 0 on the next edge.
- **Reset mid-operation:**
  - Assert `rst` with SW active -> `dmem_we`=0000.
  - Load issued the cycle before reset -> `load_data`=0.
  - Counters are 0 after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit with memory-mapped counters.
//   Store path (combinational): byte enables and lane-replicated write data
//   for the synchronous DMEM port, gated by stall/flush/region/reset.
//   Load path: address attributes are registered in the execute cycle, and the
//   word is aligned and sign/zero extended in the writeback cycle.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_rw[1:0]               store width (00 none, 01 SW, 10 SH, 11 SB)
//   ld_sel[2:0]               load funct3 (LB/LH/LW/LBU/LHU; others act as LW)
//   ld_en                     execute instruction is a load
//   addr, store_data          effective address and rs2 value
//   stall, flush              load-use hold and control-hazard kill
//   inst_retire               one instruction retired this cycle
//   dmem_addr/din/we/dout     synchronous DMEM port (dout lags addr by 1 cycle)
//   load_data                 aligned load result, valid in writeback
//   cycle_count, inst_count   free-running counters
module mem_access_unit #(
    parameter int DMEM_AWIDTH = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mem_rw,
    input  logic [2:0]             ld_sel,
    input  logic                   ld_en,
    input  logic [31:0]            addr,
    input  logic [31:0]            store_data,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   inst_retire,
    output logic [DMEM_AWIDTH-1:0] dmem_addr,
    output logic [31:0]            dmem_din,
    output logic [3:0]             dmem_we,
    input  logic [31:0]            dmem_dout,
    output logic [31:0]            load_data,
    output logic [31:0]            cycle_count,
    output logic [31:0]            inst_count
);

    localparam logic [1:0] RGN_OTHER = 2'd0;
    localparam logic [1:0] RGN_DMEM  = 2'd1;
    localparam logic [1:0] RGN_CYC   = 2'd2;
    localparam logic [1:0] RGN_INST  = 2'd3;

    localparam logic [31:0] ADDR_CYC  = 32'h8000_0010;
    localparam logic [31:0] ADDR_INST = 32'h8000_0014;
    localparam logic [31:0] ADDR_CLR  = 32'h8000_0018;

    logic        is_dmem, is_io, acc_ok, is_store, cnt_clr;
    logic [1:0]  rgn_d;
    logic [31:0] io_d;

    logic        ld_v_q;
    logic [2:0]  ld_sel_q;
    logic [1:0]  off_q, rgn_q;
    logic [31:0] io_q;

    assign is_dmem   = (addr[31:28] == 4'h1) || (addr[31:28] == 4'h3);
    assign is_io     = (addr[31:28] == 4'h8);
    // Reset is folded in so the write enables stay low while rst is high.
    assign acc_ok    = ~rst & ~stall & ~flush;
    assign is_store  = (mem_rw != 2'b00);
    assign cnt_clr   = acc_ok & is_store & is_io & (addr == ADDR_CLR);
    assign dmem_addr = addr[DMEM_AWIDTH+1:2];

    // Store path
    always_comb begin
        dmem_we  = 4'b0000;
        dmem_din = store_data;
        case (mem_rw)
            2'b01: dmem_we = 4'b1111;
            2'b10: begin
                dmem_we  = addr[1] ? 4'b1100 : 4'b0011;
                dmem_din = {2{store_data[15:0]}};
            end
            2'b11: begin
                dmem_we  = 4'b0001 << addr[1:0];
                dmem_din = {4{store_data[7:0]}};
            end
            default: dmem_we = 4'b0000;
        endcase
        if (!(acc_ok && is_dmem))
            dmem_we = 4'b0000;
    end

    // Region classification and counter snapshot for a load in execute
    always_comb begin
        rgn_d = RGN_OTHER;
        io_d  = 32'h0;
        if (is_dmem) begin
            rgn_d = RGN_DMEM;
        end else if (addr == ADDR_CYC) begin
            rgn_d = RGN_CYC;
            io_d  = cycle_count;
        end else if (addr == ADDR_INST) begin
            rgn_d = RGN_INST;
            io_d  = inst_count;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count <= 32'h0;
            inst_count  <= 32'h0;
            ld_v_q      <= 1'b0;
            ld_sel_q    <= 3'b000;
            off_q       <= 2'b00;
            rgn_q       <= RGN_OTHER;
            io_q        <= 32'h0;
        end else begin
            // Clear wins over increment, including a same-cycle retire.
            if (cnt_clr) begin
                cycle_count <= 32'h0;
                inst_count  <= 32'h0;
            end else begin
                cycle_count <= cycle_count + 32'd1;
                inst_count  <= inst_count + {31'h0, inst_retire};
            end
            if (!stall) begin
                ld_v_q   <= ld_en & ~flush;
                ld_sel_q <= ld_sel;
                off_q    <= addr[1:0];
                rgn_q    <= rgn_d;
                io_q     <= io_d;
            end
        end
    end

    // Writeback-cycle extraction
    logic [31:0] src;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (rgn_q)
            RGN_DMEM:          src = dmem_dout;
            RGN_CYC, RGN_INST: src = io_q;
            default:           src = 32'h0;
        endcase
        case (off_q)
            2'd0:    byte_v = src[7:0];
            2'd1:    byte_v = src[15:8];
            2'd2:    byte_v = src[23:16];
            default: byte_v = src[31:24];
        endcase
        half_v = off_q[1] ? src[31:16] : src[15:0];
        case (ld_sel_q)
            3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_data = {{16{half_v[15]}}, half_v};
            3'b100:  load_data = {24'h0, byte_v};
            3'b101:  load_data = {16'h0, half_v};
            default: load_data = src;
        endcase
        if (!ld_v_q)
            load_data = 32'h0;
    end

endmodule
